// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, requester ids and slot type for the regfile writeback arbiter
package regfile_arb_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: two writeback requesters in, registered regfile write port out
interface regfile_wb_arbiter_if #(
  parameter int DW = regfile_arb_pkg::DW,
  parameter int AW = regfile_arb_pkg::AW
);
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd;
  logic          we;
  logic          gnt;
  logic          idle;
  modport slave (
    input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready, a3, wd, we, gnt, idle
  );
  modport master (
    output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready, a3, wd, we, gnt, idle
  );
endinterface

// File: rtl/wb_slot.sv
// wb_slot: one-entry writeback buffer; an accept on a drain edge refills it in place
module wb_slot #(
  parameter int DW = regfile_arb_pkg::DW,
  parameter int AW = regfile_arb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          drain,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    full_d = accept | (full_q & ~drain);
    addr_d = accept ? in_addr : addr_q;
    data_d = accept ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the regfile write port between two writeback sources
module regfile_wb_arbiter #(
  parameter int DW = regfile_arb_pkg::DW,
  parameter int AW = regfile_arb_pkg::AW
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  import regfile_arb_pkg::*;
  logic          full0, full1, drain0, drain1, ready0, ready1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          prio_q, prio_d, we_q, we_d, gnt_q, gnt_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;
  wb_slot #(.DW(DW), .AW(AW)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .accept(bus.s0_valid & ready0), .drain(drain0),
    .in_addr(bus.s0_addr), .in_data(bus.s0_data), .full(full0), .addr(addr0), .data(data0)
  );
  wb_slot #(.DW(DW), .AW(AW)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .accept(bus.s1_valid & ready1), .drain(drain1),
    .in_addr(bus.s1_addr), .in_data(bus.s1_data), .full(full1), .addr(addr1), .data(data1)
  );
  // drain depends only on slot state and prio, keeping ready free of any path from valid
  always_comb begin
    drain0 = full0 & (~full1 | (prio_q == REQ0));
    drain1 = full1 & (~full0 | (prio_q == REQ1));
    ready0 = ~full0 | drain0;
    ready1 = ~full1 | drain1;
    prio_d = drain0 ? REQ1 : drain1 ? REQ0 : prio_q;
    gnt_d  = drain0 ? REQ0 : drain1 ? REQ1 : gnt_q;
    a3_d   = drain0 ? addr0 : drain1 ? addr1 : a3_q;
    wd_d   = drain0 ? data0 : drain1 ? data1 : wd_q;
    we_d   = drain0 ? |addr0 : drain1 ? |addr1 : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ0;
      gnt_q  <= REQ0;
      we_q   <= 1'b0;
      a3_q   <= '0;
      wd_q   <= '0;
    end else begin
      prio_q <= prio_d;
      gnt_q  <= gnt_d;
      we_q   <= we_d;
      a3_q   <= a3_d;
      wd_q   <= wd_d;
    end
  end
  assign bus.s0_ready = ready0;
  assign bus.s1_ready = ready1;
  assign bus.a3       = a3_q;
  assign bus.wd       = wd_q;
  assign bus.we       = we_q;
  assign bus.gnt      = gnt_q;
  assign bus.idle     = ~full0 & ~full1 & ~we_q;
endmodule
